divyasree_flashadc_ctrl: RTL and testbench

DIVYASREE_FLASHADC_CTRL -- requirements
Module: divyasree_flashadc_ctrl

---
 rtl/divyasree_flashadc_ctrl.sv | 155 +++++++++++++++
 tb/tb_divyasree_flashadc_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/divyasree_flashadc_ctrl.sv
// Flash-ADC conversion controller: track/settle/capture sequencing, thermometer-to-binary
// encoding with bubble and over-range flags, and a valid/ready output handshake.
module divyasree_flashadc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  settle_cycles,
    input  logic [15:0] therm,
    output logic        sh_en,
    output logic        busy,
    output logic [3:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        bubble_err,
    output logic        ovr,
    output logic [7:0]  conv_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   s_q, s_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         trk_q, trk_d;
    logic [15:1]  cap_q, cap_d;
    logic [3:0]   dout_q, dout_d;
    logic         bubble_q, bubble_d;
    logic         ovr_q, ovr_d;
    logic         valid_q, valid_d;
    logic [7:0]   count_q, count_d;

    // Bit 0 of the comparator bank carries no information.
    logic         unused_therm0;
    assign unused_therm0 = therm[0];

    function automatic logic [3:0] therm_encode(input logic [15:1] t);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 1; i <= 15; i++) begin
            if (t[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic therm_bubble(input logic [15:1] t);
        logic seen_zero;
        logic bad;
        seen_zero = 1'b0;
        bad       = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (!t[i])         seen_zero = 1'b1;
            else if (seen_zero) bad      = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        trk_d    = trk_q;
        dout_d   = dout_q;
        bubble_d = bubble_q;
        ovr_d    = ovr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = settle_cycles;
                    trk_d   = 1'b0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (trk_q) begin
                    cnt_d   = s_q;
                    state_d = SETTLE;
                end else begin
                    trk_d = 1'b1;
                end
            end
            SETTLE: begin
                // Counter is loaded with S, so S+1 cycles elapse before it reads zero.
                if (cnt_q == 4'd0) state_d = CAPTURE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            CAPTURE: begin
                state_d = OUT;
            end
            OUT: begin
                // First OUT cycle encodes the captured word; results are then held until accepted.
                if (!valid_q) begin
                    valid_d  = 1'b1;
                    dout_d   = therm_encode(cap_q);
                    bubble_d = therm_bubble(cap_q);
                    ovr_d    = cap_q[15];
                end else if (dout_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_d = cap_q;
        if (state_q == CAPTURE) cap_d = therm[15:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= 4'd0;
            cnt_q    <= 4'd0;
            trk_q    <= 1'b0;
            dout_q   <= 4'd0;
            bubble_q <= 1'b0;
            ovr_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            trk_q    <= trk_d;
            dout_q   <= dout_d;
            bubble_q <= bubble_d;
            ovr_q    <= ovr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    assign sh_en      = (state_q == TRACK);
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign bubble_err = bubble_q;
    assign ovr        = ovr_q;
    assign dout_valid = valid_q;
    assign conv_count = count_q;

endmodule

// File: tb/tb_divyasree_flashadc_ctrl.sv
// Directed bench for divyasree_flashadc_ctrl with a queue-based scoreboard of expected
// {dout, bubble_err, ovr} results.
module tb_divyasree_flashadc_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  settle_cycles;
    logic [15:0] therm;
    logic        sh_en;
    logic        busy;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        bubble_err;
    logic        ovr;
    logic [7:0]  conv_count;

    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_cnt;
    logic [5:0]  exp_q[$];

    divyasree_flashadc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .settle_cycles (settle_cycles),
        .therm         (therm),
        .sh_en         (sh_en),
        .busy          (busy),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .bubble_err    (bubble_err),
        .ovr           (ovr),
        .conv_count    (conv_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] model_dout(input logic [15:0] t);
        for (int i = 15; i >= 1; i--) begin
            if (t[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // A clean code on bits 15:1 is 2^n-1 after dropping bit 0.
    function automatic logic model_bubble(input logic [15:0] t);
        logic [15:0] x;
        x = {1'b0, t[15:1]};
        return (x & (x + 16'd1)) != 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input logic [5:0] e, input string tag);
        chk({tag, "_dout"},   {28'd0, dout}, {28'd0, e[5:2]});
        chk({tag, "_bubble"}, {31'd0, bubble_err}, {31'd0, e[1]});
        chk({tag, "_ovr"},    {31'd0, ovr}, {31'd0, e[0]});
    endtask

    // One full conversion; hold>0 keeps dout_ready low for that many OUT cycles while pulsing start.
    task automatic convert(input logic [3:0] s, input logic [15:0] t, input int hold, input string tag);
        logic [5:0] e;
        exp_q.push_back({model_dout(t), model_bubble(t), t[15]});
        dout_ready    = (hold == 0);
        settle_cycles = s;
        therm         = ~t;
        start         = 1'b1;
        step();
        start         = 1'b0;
        settle_cycles = ~s;
        therm         = 16'($urandom);
        chk({tag, "_sh_en_t0"}, {31'd0, sh_en}, 32'd1);
        chk({tag, "_busy_t0"},  {31'd0, busy},  32'd1);
        step();
        chk({tag, "_sh_en_t1"}, {31'd0, sh_en}, 32'd1);
        step();
        chk({tag, "_sh_en_settle"}, {31'd0, sh_en}, 32'd0);
        repeat (int'(s) + 1) step();
        therm = t;
        step();
        therm = 16'($urandom);
        chk({tag, "_valid_early"}, {31'd0, dout_valid}, 32'd0);
        step();
        chk({tag, "_valid_lat"}, {31'd0, dout_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            e = 6'd0;
        end else begin
            e = exp_q.pop_front();
        end
        check_out(e, tag);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                start = 1'b1;
                therm = 16'($urandom);
                step();
                chk({tag, "_hold_valid"}, {31'd0, dout_valid}, 32'd1);
                check_out(e, {tag, "_hold"});
            end
            dout_ready = 1'b1;
        end
        step();
        start      = 1'b0;
        dout_ready = 1'b0;
        exp_cnt    = exp_cnt + 8'd1;
        chk({tag, "_valid_clr"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_count"}, {24'd0, conv_count}, {24'd0, exp_cnt});
    endtask

    initial begin
        logic [15:0] t;
        int          n;
        n_tests       = 0;
        n_fail        = 0;
        exp_cnt       = 8'd0;
        rst           = 1'b1;
        start         = 1'b0;
        settle_cycles = 4'd0;
        therm         = 16'd0;
        dout_ready    = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_sh_en", {31'd0, sh_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {28'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_bubble", {31'd0, bubble_err}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);
        chk("rst_count", {24'd0, conv_count}, 32'd0);

        // Ready asserted outside OUT must not disturb the conversion.
        convert(4'd0, 16'h07FE, 0, "basic");
        convert(4'd2, 16'hFDFE, 0, "bubble_ovr");
        convert(4'd15, 16'h0000, 10, "zero_bp");
        convert(4'd1, 16'hFFFE, 2, "full");

        // Reset during SETTLE with start and ready also high.
        settle_cycles = 4'd5;
        therm         = 16'h00FE;
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("mid_in_settle", {31'd0, busy}, 32'd1);
        rst        = 1'b1;
        start      = 1'b1;
        dout_ready = 1'b1;
        step();
        rst        = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sh_en", {31'd0, sh_en}, 32'd0);
        chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("mid_rst_count", {24'd0, conv_count}, 32'd0);
        exp_cnt = 8'd0;
        repeat (12) step();
        chk("mid_no_resume", {31'd0, dout_valid}, 32'd0);

        for (int i = 0; i < 256; i++) begin
            n = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) t = 16'(((32'd1 << n) - 32'd1) << 1) | 16'($urandom_range(0, 1));
            else                           t = 16'($urandom);
            convert(4'($urandom_range(0, 3)), t, (i % 17 == 0) ? 1 : 0, "wrap");
        end
        chk("wrap_zero", {24'd0, conv_count}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
